// File: rtl/dcm_multi_controller.sv
// dcm_multi_controller
//
// Decodes in-band clock commands from the work-packet stream and serially
// programs up to NUM_DCM DCM_CLKGEN primitives. PROGDATA is shared and each
// DCM has its own PROGEN and PROGDONE. Each channel has its own target
// multiplier. Targets are clamped to [MIN_MULT, MAX_MULT]. A channel whose
// target differs from its last programmed value is queued for programming.
// Every channel is programmed automatically after reset.
//
// Optional feature: define DCM_RETRY_EN to rerun a timed-out sequence once
// before flagging dcm_err.
//
// Ports
//   clk            system clock, also used as DCM PROGCLK
//   rst_n          asynchronous active-low reset
//   start          one-cycle strobe: midstate/data2 valid
//   midstate       work midstate (must be zero for a command)
//   data2          work data2 (command fields in [95:64], marker in [63:32])
//   dcm_prog_en    per-DCM PROGEN
//   dcm_prog_data  shared PROGDATA (0 whenever no PROGEN is high)
//   dcm_prog_done  per-DCM PROGDONE
//   busy           programming sequence in progress
//   cmd_ack        pulse: command accepted
//   cmd_nak        pulse: trigger seen but command rejected
//   current_mult   last successfully programmed M, channel i at [8i+7:8i]
//   dcm_err        sticky PROGDONE timeout flag per channel
module dcm_multi_controller #(
    parameter int unsigned NUM_DCM        = 2,
    parameter int unsigned MIN_MULT       = 2,
    parameter int unsigned MAX_MULT       = 64,
    parameter int unsigned INIT_MULT      = 16,
    parameter int unsigned DIVIDER        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [255:0]           midstate,
    input  logic [255:0]           data2,
    output logic [NUM_DCM-1:0]     dcm_prog_en,
    output logic                   dcm_prog_data,
    input  logic [NUM_DCM-1:0]     dcm_prog_done,
    output logic                   busy,
    output logic                   cmd_ack,
    output logic                   cmd_nak,
    output logic [8*NUM_DCM-1:0]   current_mult,
    output logic [NUM_DCM-1:0]     dcm_err
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SHIFT = 2'd1;
    localparam logic [1:0]  ST_WAIT  = 2'd2;

    localparam logic [4:0]  K_LAST   = 5'd25;
    localparam logic [7:0]  DIV_M1   = 8'(DIVIDER - 1);
    localparam logic [8:0]  MIN9     = 9'(MIN_MULT);
    localparam logic [8:0]  MAX9     = 9'(MAX_MULT);
    localparam logic [7:0]  INIT8    = 8'(INIT_MULT);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [4:0]         k_q, k_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         mult_q, mult_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_DCM-1:0] pending_q, pending_d;
    logic [NUM_DCM-1:0] err_q, err_d;
    logic [7:0]         target_q [NUM_DCM];
    logic [7:0]         target_d [NUM_DCM];
    logic [7:0]         cur_q [NUM_DCM];
    logic [7:0]         cur_d [NUM_DCM];
`ifdef DCM_RETRY_EN
    logic               retry_q, retry_d;
`endif

    logic [NUM_DCM-1:0] en_q;
    logic               data_q, busy_q, ack_q, nak_q;

    // Command decode
    logic [7:0] c_id, c_arg, c_chan, c_chk;
    logic       trig, chan_ok, cmd_ok;
    logic       unused_data2;

    assign c_id    = data2[71:64];
    assign c_arg   = data2[79:72];
    assign c_chan  = data2[87:80];
    assign c_chk   = data2[95:88];
    assign trig    = start && (data2[63:32] == 32'hFFFF_FFFF) && (midstate == '0);
    assign chan_ok = (c_chan == 8'hFF) || (32'(c_chan) < NUM_DCM);
    assign cmd_ok  = (c_chk == (c_id ^ c_arg ^ c_chan)) &&
                     (c_id == 8'h01 || c_id == 8'h02 || c_id == 8'h03) && chan_ok;
    assign unused_data2 = ^{data2[255:96], data2[31:0]};

    // 9-bit arithmetic so UP at 255 cannot wrap; DOWN saturates at 0 before clamping.
    function automatic logic [7:0] next_target(input logic [7:0] id, input logic [7:0] arg,
                                               input logic [7:0] cur);
        logic [8:0] raw;
        case (id)
            8'h01:   raw = {1'b0, arg};
            8'h02:   raw = {1'b0, cur} + 9'd1;
            default: raw = (cur == 8'd0) ? 9'd0 : {1'b0, cur} - 9'd1;
        endcase
        if (raw < MIN9)      next_target = MIN9[7:0];
        else if (raw > MAX9) next_target = MAX9[7:0];
        else                 next_target = raw[7:0];
    endfunction

    // Selected channel as a one-hot mask
    logic [NUM_DCM-1:0] sel_oh;
    logic               done_hit;

    always_comb begin
        for (int i = 0; i < NUM_DCM; i++) sel_oh[i] = (sel_q == 3'(i));
    end
    assign done_hit = |(dcm_prog_done & sel_oh);

    // Serial frame for cycle k: LoadD, gap, LoadM, gap, GO
    logic [7:0] mult_m1;
    logic       seq_en, seq_bit;

    always_comb begin
        mult_m1 = mult_q - 8'd1;
        seq_en  = 1'b0;
        seq_bit = 1'b0;
        if (k_q <= 5'd1) begin
            seq_en  = 1'b1;
            seq_bit = (k_q == 5'd0);
        end else if (k_q <= 5'd9) begin
            seq_en  = 1'b1;
            seq_bit = DIV_M1[k_q[2:0] - 3'd2];
        end else if (k_q <= 5'd12) begin
            seq_en  = 1'b0;
        end else if (k_q <= 5'd14) begin
            seq_en  = 1'b1;
            seq_bit = 1'b1;
        end else if (k_q <= 5'd22) begin
            seq_en  = 1'b1;
            seq_bit = mult_m1[k_q[2:0] - 3'd7];
        end else if (k_q == K_LAST) begin
            seq_en  = 1'b1;
            seq_bit = 1'b0;
        end
    end

    // Scheduler, sequencer and command update
    logic       found;
    logic [7:0] nt;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        sel_d     = sel_q;
        mult_d    = mult_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        err_d     = err_q;
        found     = 1'b0;
        nt        = '0;
`ifdef DCM_RETRY_EN
        retry_d   = retry_q;
`endif
        for (int i = 0; i < NUM_DCM; i++) begin
            target_d[i] = target_q[i];
            cur_d[i]    = cur_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    for (int i = 0; i < NUM_DCM; i++) begin
                        if (pending_q[i] && !found) begin
                            found        = 1'b1;
                            sel_d        = 3'(i);
                            mult_d       = target_q[i];
                            pending_d[i] = 1'b0;
                        end
                    end
                    state_d = ST_SHIFT;
                    k_d     = '0;
`ifdef DCM_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (k_q == K_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            ST_WAIT: begin
                if (done_hit) begin
                    for (int i = 0; i < NUM_DCM; i++) begin
                        if (sel_oh[i]) cur_d[i] = mult_q;
                    end
                    state_d = ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
`ifdef DCM_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = ST_SHIFT;
                        k_d     = '0;
                    end else begin
                        err_d   = err_q | sel_oh;
                        state_d = ST_IDLE;
                    end
`else
                    err_d   = err_q | sel_oh;
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied after the scheduler so a command re-queues the channel
        // even if the scheduler just picked it.
        if (trig && cmd_ok) begin
            for (int i = 0; i < NUM_DCM; i++) begin
                if (c_chan == 8'hFF || c_chan == 8'(i)) begin
                    nt          = next_target(c_id, c_arg, target_q[i]);
                    target_d[i] = nt;
                    if (nt != cur_q[i] || err_q[i]) pending_d[i] = 1'b1;
                    err_d[i]    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            sel_q     <= '0;
            mult_q    <= INIT8;
            cnt_q     <= '0;
            pending_q <= '1;
            err_q     <= '0;
            for (int i = 0; i < NUM_DCM; i++) begin
                target_q[i] <= INIT8;
                cur_q[i]    <= '0;
            end
`ifdef DCM_RETRY_EN
            retry_q   <= 1'b0;
`endif
            en_q      <= '0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            nak_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            sel_q     <= sel_d;
            mult_q    <= mult_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_DCM; i++) begin
                target_q[i] <= target_d[i];
                cur_q[i]    <= cur_d[i];
            end
`ifdef DCM_RETRY_EN
            retry_q   <= retry_d;
`endif
            // Output stage trails the sequencer state by one cycle
            en_q      <= (state_q == ST_SHIFT && seq_en) ? sel_oh : '0;
            data_q    <= (state_q == ST_SHIFT) && seq_en && seq_bit;
            busy_q    <= (state_q != ST_IDLE);
            ack_q     <= trig && cmd_ok;
            nak_q     <= trig && !cmd_ok;
        end
    end

    assign dcm_prog_en   = en_q;
    assign dcm_prog_data = data_q;
    assign busy          = busy_q;
    assign cmd_ack       = ack_q;
    assign cmd_nak       = nak_q;
    assign dcm_err       = err_q;

    for (genvar g = 0; g < NUM_DCM; g++) begin : g_cur
        assign current_mult[8*g +: 8] = cur_q[g];
    end

endmodule

// File: tb/tb_dcm_multi_controller.sv
`timescale 1ns/1ps
module tb_dcm_multi_controller;

    localparam int NDCM = 2;
    localparam int MINM = 2;
    localparam int MAXM = 64;
    localparam int INIT = 16;
    localparam int DIV  = 8;
    localparam int TMO  = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] midstate = '0;
    logic [255:0] data2 = '0;
    logic [1:0]   dcm_prog_en;
    logic         dcm_prog_data;
    logic [1:0]   dcm_prog_done;
    logic         busy, cmd_ack, cmd_nak;
    logic [15:0]  current_mult;
    logic [1:0]   dcm_err;

    dcm_multi_controller #(
        .NUM_DCM(NDCM), .MIN_MULT(MINM), .MAX_MULT(MAXM), .INIT_MULT(INIT),
        .DIVIDER(DIV), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .midstate(midstate), .data2(data2),
        .dcm_prog_en(dcm_prog_en), .dcm_prog_data(dcm_prog_data),
        .dcm_prog_done(dcm_prog_done), .busy(busy), .cmd_ack(cmd_ack), .cmd_nak(cmd_nak),
        .current_mult(current_mult), .dcm_err(dcm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural DCM: decodes PROGEN runs into LoadD / LoadM / GO frames and
    // answers GO with a one-cycle PROGDONE after done_delay cycles.
    logic [15:0] run_bits [2];
    int          run_len [2];
    int          m_prog [2];
    int          last_m [2];
    int          go_cnt [2];
    int          go_cycle [2];
    int          done_timer [2];
    bit          hold_low [2];
    int          done_delay = 5;
    int          go_order [$];
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                run_len[c]       = 0;
                done_timer[c]    = 0;
                dcm_prog_done[c] = 1'b0;
            end
        end else begin
            check("en_onehot", ($countones(dcm_prog_en) <= 1), 1);
            if (dcm_prog_en == 2'b00) check("data_when_idle", dcm_prog_data, 0);
            for (int c = 0; c < 2; c++) begin
                dcm_prog_done[c] = 1'b0;
                if (done_timer[c] > 0) begin
                    done_timer[c]--;
                    if (done_timer[c] == 0) dcm_prog_done[c] = 1'b1;
                end
                if (dcm_prog_en[c]) begin
                    if (run_len[c] < 16) run_bits[c][run_len[c]] = dcm_prog_data;
                    run_len[c]++;
                end else if (run_len[c] > 0) begin
                    if (run_len[c] == 10 && run_bits[c][1:0] == 2'b01) begin
                        check("loadd_value", run_bits[c][9:2], DIV - 1);
                    end else if (run_len[c] == 10 && run_bits[c][1:0] == 2'b11) begin
                        m_prog[c] = int'(run_bits[c][9:2]) + 1;
                    end else if (run_len[c] == 1 && run_bits[c][0] == 1'b0) begin
                        go_cnt[c]++;
                        last_m[c]   = m_prog[c];
                        go_cycle[c] = cyc;
                        go_order.push_back(c);
                        if (!hold_low[c]) done_timer[c] = done_delay;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL frame_shape ch%0d: got len %0d, expected len 10 or 1",
                                 c, run_len[c]);
                    end
                    run_len[c] = 0;
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] id, input logic [7:0] arg, input logic [7:0] chan,
                            input bit bad, input bit notrig, output logic a, output logic n);
        logic [7:0] chk;
        chk = id ^ arg ^ chan;
        if (bad) chk = chk ^ 8'h5A;
        @(negedge clk);
        data2 = '0;
        data2[31:0]   = $urandom;
        data2[63:32]  = 32'hFFFF_FFFF;
        data2[71:64]  = id;
        data2[79:72]  = arg;
        data2[87:80]  = chan;
        data2[95:88]  = chk;
        data2[127:96] = $urandom;
        midstate = '0;
        if (notrig) midstate[200] = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = cmd_ack;
        n = cmd_nak;
        data2 = '0;
        midstate = '0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 4000) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        check({name, "_settle"}, quiet, 8);
    endtask

    task automatic wait_go(input int ch, input int target, input string name);
        int n = 0;
        while (go_cnt[ch] < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_go_seen"}, (go_cnt[ch] >= target), 1);
    endtask

    typedef struct {
        logic [7:0] id;
        logic [7:0] arg;
        logic [7:0] chan;
        bit         bad;
        bit         notrig;
        bit         ack;
        bit         nak;
        logic [7:0] m0;
        logic [7:0] m1;
        int         seqs;
    } vec_t;

    vec_t tbl [13];

    function automatic int model_next(input int id, input int arg, input int t);
        int v;
        case (id)
            1:       v = arg;
            2:       v = t + 1;
            default: v = t - 1;
        endcase
        if (v < MINM) v = MINM;
        if (v > MAXM) v = MAXM;
        return v;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, n;
        int   g0, g1, base, t_err, w;
        int   mt [2];
        int   exp_go [2];
        bit   valid;
        logic [7:0] rid, rarg, rchan;
        bit   rbad;

        tbl[0]  = '{8'h01, 8'd100, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd16, 8'd64, 1};
        tbl[1]  = '{8'h01, 8'd30,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16, 8'd64, 0};
        tbl[2]  = '{8'h01, 8'd30,  8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16, 8'd64, 0};
        tbl[3]  = '{8'h01, 8'd0,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  8'd64, 1};
        tbl[4]  = '{8'h03, 8'd0,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  8'd64, 0};
        tbl[5]  = '{8'h02, 8'd9,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3,  8'd64, 1};
        tbl[6]  = '{8'h04, 8'd9,   8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3,  8'd64, 0};
        tbl[7]  = '{8'h01, 8'd40,  8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd40, 2};
        tbl[8]  = '{8'h02, 8'd7,   8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd41, 1};
        tbl[9]  = '{8'h01, 8'd255, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd64, 1};
        tbl[10] = '{8'h02, 8'd0,   8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd64, 0};
        tbl[11] = '{8'h03, 8'd0,   8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd39, 8'd63, 2};
        tbl[12] = '{8'h01, 8'd50,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd39, 8'd63, 0};

        for (int c = 0; c < 2; c++) begin
            go_cnt[c] = 0; hold_low[c] = 1'b0; m_prog[c] = 0; last_m[c] = 0;
            go_cycle[c] = 0; run_len[c] = 0; done_timer[c] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_en", dcm_prog_en, 0);
        check("rst_data", dcm_prog_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", cmd_ack, 0);
        check("rst_nak", cmd_nak, 0);
        check("rst_mult", current_mult, 0);
        check("rst_err", dcm_err, 0);

        // Automatic programming after release: ch0 first, then ch1, both M=16
        rst_n = 1'b1;
        w = 0;
        while (dcm_prog_en == 2'b00 && w < 4) begin
            @(negedge clk);
            w++;
        end
        check("boot_first_en_ch0", dcm_prog_en, 2'b01);
        check("boot_busy", busy, 1);
        wait_idle("boot");
        check("boot_seq_count", go_order.size(), 2);
        if (go_order.size() == 2) begin
            check("boot_order0", go_order[0], 0);
            check("boot_order1", go_order[1], 1);
        end
        check("boot_m0", last_m[0], INIT);
        check("boot_m1", last_m[1], INIT);
        check("boot_mult", current_mult, {8'd16, 8'd16});
        check("boot_err", dcm_err, 0);

        // Table-driven commands
        for (int i = 0; i < 13; i++) begin
            g0 = go_cnt[0] + go_cnt[1];
            send_cmd(tbl[i].id, tbl[i].arg, tbl[i].chan, tbl[i].bad, tbl[i].notrig, a, n);
            check($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
            check($sformatf("tbl%0d_nak", i), n, tbl[i].nak);
            wait_idle($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_m0", i), current_mult[7:0], tbl[i].m0);
            check($sformatf("tbl%0d_m1", i), current_mult[15:8], tbl[i].m1);
            check($sformatf("tbl%0d_seqs", i), go_cnt[0] + go_cnt[1] - g0, tbl[i].seqs);
        end

        // New SET to ch0 while ch0 waits for PROGDONE: both sequences run in order
        done_delay = 30;
        base = go_cnt[0];
        send_cmd(8'h01, 8'd25, 8'h00, 1'b0, 1'b0, a, n);
        check("busyset_ack1", a, 1);
        wait_go(0, base + 1, "busyset");
        check("busyset_first_m", last_m[0], 25);
        send_cmd(8'h01, 8'd20, 8'h00, 1'b0, 1'b0, a, n);
        check("busyset_ack2", a, 1);
        wait_idle("busyset");
        check("busyset_seqs", go_cnt[0] - base, 2);
        check("busyset_second_m", last_m[0], 20);
        check("busyset_mult0", current_mult[7:0], 20);
        done_delay = 5;

        // PROGDONE held low on ch0: timeout flag, multiplier unchanged
        hold_low[0] = 1'b1;
        base = go_cnt[0];
        send_cmd(8'h01, 8'd10, 8'h00, 1'b0, 1'b0, a, n);
        check("tmo_ack", a, 1);
        w = 0;
        while (!dcm_err[0] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        t_err = cyc;
        check("tmo_err_seen", dcm_err[0], 1);
        check("tmo_window", (t_err - go_cycle[0] >= TMO - 5) && (t_err - go_cycle[0] <= TMO + 5), 1);
        wait_idle("tmo");
`ifdef DCM_RETRY_EN
        check("tmo_seqs", go_cnt[0] - base, 2);
`else
        check("tmo_seqs", go_cnt[0] - base, 1);
`endif
        check("tmo_err", dcm_err, 2'b01);
        check("tmo_mult0", current_mult[7:0], 20);
        hold_low[0] = 1'b0;
        send_cmd(8'h01, 8'd10, 8'h00, 1'b0, 1'b0, a, n);
        check("tmo_clear_ack", a, 1);
        check("tmo_clear_err", dcm_err, 0);
        wait_idle("tmo_clear");
        check("tmo_clear_mult0", current_mult[7:0], 10);

        // Reset asserted mid-sequence
        send_cmd(8'h01, 8'd50, 8'h01, 1'b0, 1'b0, a, n);
        w = 0;
        while (!dcm_prog_en[1] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("midrst_started", dcm_prog_en[1], 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", dcm_prog_en, 0);
        check("midrst_data", dcm_prog_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mult", current_mult, 0);
        check("midrst_err", dcm_err, 0);
        repeat (2) @(negedge clk);
        g0 = go_cnt[0];
        g1 = go_cnt[1];
        rst_n = 1'b1;
        wait_idle("midrst");
        check("midrst_seq0", go_cnt[0] - g0, 1);
        check("midrst_seq1", go_cnt[1] - g1, 1);
        check("midrst_mult_after", current_mult, {8'd16, 8'd16});

        // Random commands against the reference model
        mt[0] = INIT;
        mt[1] = INIT;
        for (int it = 0; it < 25; it++) begin
            w = $urandom_range(0, 9);
            if (w < 3)       rid = 8'h01;
            else if (w < 6)  rid = 8'h02;
            else if (w < 8)  rid = 8'h03;
            else if (w == 8) rid = 8'h00;
            else             rid = 8'($urandom_range(4, 255));
            w = $urandom_range(0, 9);
            if (w < 4)       rchan = 8'h00;
            else if (w < 7)  rchan = 8'h01;
            else if (w < 9)  rchan = 8'hFF;
            else             rchan = 8'($urandom_range(2, 254));
            rarg = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 80))
                                               : 8'($urandom_range(0, 255));
            rbad = ($urandom_range(0, 7) == 0);
            valid = !rbad && (rid >= 8'h01 && rid <= 8'h03) && (rchan < 2 || rchan == 8'hFF);
            for (int c = 0; c < 2; c++) begin
                exp_go[c] = 0;
                if (valid && (rchan == 8'hFF || int'(rchan) == c)) begin
                    g0 = model_next(int'(rid), int'(rarg), mt[c]);
                    if (g0 != mt[c]) exp_go[c] = 1;
                    mt[c] = g0;
                end
            end
            g0 = go_cnt[0];
            g1 = go_cnt[1];
            send_cmd(rid, rarg, rchan, rbad, 1'b0, a, n);
            check($sformatf("rnd%0d_ack", it), a, valid);
            check($sformatf("rnd%0d_nak", it), n, !valid);
            wait_idle($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_m0", it), current_mult[7:0], mt[0]);
            check($sformatf("rnd%0d_m1", it), current_mult[15:8], mt[1]);
            check($sformatf("rnd%0d_seq0", it), go_cnt[0] - g0, exp_go[0]);
            check($sformatf("rnd%0d_seq1", it), go_cnt[1] - g1, exp_go[1]);
            check($sformatf("rnd%0d_err", it), dcm_err, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
